lsu_dmem_if: RTL and testbench
==============================

Name: lsu_dmem_if

Overview:
- Load/store unit between the core's memory stage and a handshaked data memory.
- Produces the `read_data` word that the writeback mux selects when ResultSrc=1.
- Formats stores: byte lanes, byte enables and replicated write data.
- Formats loads: lane extraction with sign or zero extension.
- Holds the core with `stall` until the memory transaction completes.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT_CYCLES, 16, cycles spent in REQ+WAIT_R before a bus error is declared (1..255).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  load request from decode/control.
- mem_write  in  1  store request from decode/control.
- funct3  in  3  RV32I load/store width and sign code.
- addr  in  ADDR_W  byte address from the ALU.
- store_data  in  32  rs2 value.
- read_data  out  32  formatted load result to writeback (registered).
- stall  out  1  hold PC and pipeline.
- misaligned  out  1  one-cycle pulse: misaligned access, no bus request issued.
- bus_err  out  1  one-cycle pulse: timeout or illegal funct3.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1=write.
- dmem_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_gnt  in  1  memory accepts request this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read data word.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, timeout counter=0.
  - read_data=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0.
  - misaligned=0, bus_err=0.
  - stall is combinational from state and inputs; it is 0 while in reset.
- Request priority: mem_read has priority when mem_read and mem_write are both 1; the store is ignored.
- Alignment check, in IDLE:
  - Half access (funct3[1:0]=01) with addr[0]=1 is misaligned.
  - Word access (funct3=010) with addr[1:0]!=0 is misaligned.
  - Response: misaligned pulses 1 cycle, no dmem_req, stall=0, state stays IDLE.
- Illegal funct3:
  - Loads: 011, 110, 111. Stores: any value other than 000/001/010.
  - Response: bus_err pulses 1 cycle, no request, stall=0.
- FSM states: IDLE, REQ, WAIT_R, DONE.
  - IDLE: on a legal, aligned access, latch address, lane, funct3, formatted wdata and be; go to REQ. stall=1 combinationally in that same cycle.
  - REQ: dmem_req=1 with all bus outputs stable until dmem_gnt. On gnt, a write goes to DONE and a read goes to WAIT_R. stall=1.
  - WAIT_R: on dmem_rvalid, capture the formatted load into read_data and go to DONE. stall=1. dmem_req=0.
  - DONE: stall=0 for exactly one cycle so the instruction commits; go to IDLE. A new request is evaluated in the following cycle.
- Store formatting:
  - SB: wdata={4{sd[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SW: wdata=sd, be=1111.
- Load formatting:
  - Select the byte at rdata[8*addr[1:0]+:8], or the half at rdata[16*addr[1]+:16].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Hold rule: read_data holds its value until the next load completes. Stores, errors and idle cycles leave it unchanged.
- Timeout:
  - The counter increments each cycle in REQ or WAIT_R and clears on leaving them.
  - When it reaches TIMEOUT_CYCLES: bus_err pulses, read_data=0 for loads, dmem_req drops, go to DONE.
- dmem_rvalid arriving in IDLE, REQ or DONE is ignored. This covers a late response after a timeout.
- Reset mid-transaction: dmem_req drops immediately (async) and the FSM returns to IDLE. Any pending rvalid is ignored.
- Gnt and rvalid in the same cycle in REQ: gnt is taken and the transition is to WAIT_R. rvalid is not consumed; memory must present rvalid no earlier than the cycle after gnt.
- Minimum latency:
  - Store: 3 cycles (IDLE→REQ→DONE) with gnt in the first REQ cycle.
  - Load: 4 cycles (IDLE→REQ→WAIT_R→DONE) with gnt in the first REQ cycle and rvalid in the next.

Decomposition:
- Shared package `lsu_pkg`:
  - funct3 localparams F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - FSM state encoding (2 bits).
- Sub-module `lsu_load_fmt`: combinational lane select plus sign/zero extend (rdata, addr[1:0], funct3 → 32-bit). It is reusable by a future cache.

Test Plan:
- SW, addr=0x100, sd=0xDEADBEEF, gnt on the 2nd REQ cycle → dmem_addr=0x100, be=1111, wdata=0xDEADBEEF; stall high for 3 cycles, then low for 1.
- LB, addr=0x203, rdata=0x80FF7F01, rvalid one cycle after gnt → read_data=0xFFFFFF80. LBU at the same address → 0x00000080. LH at addr=0x202 → 0xFFFF80FF.
- SB, addr=0x41, sd=0x000000AB → be=0010, wdata=0xABABABAB. SH at addr=0x42, sd=0x1234 → be=1100, wdata=0x12341234.
- LW, addr=0x102 → misaligned pulses 1 cycle, dmem_req never asserts, stall=0, read_data unchanged.
- LW with dmem_gnt never asserted, TIMEOUT_CYCLES=16 → bus_err pulses after 16 REQ cycles, read_data=0, FSM passes through DONE then IDLE.
- Load in WAIT_R, rst_n pulsed low → dmem_req=0 and read_data=0 immediately; a later rvalid=1 with rdata=0x55 leaves read_data=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states
// and the store-side formatting helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2,
        S_DONE   = 2'd3
    } lsu_state_e;

    // Loads accept the five RV32I widths, stores only B/H/W.
    function automatic logic f3_legal(
        input logic       is_load,
        input logic [2:0] f3
    );
        logic ok;
        ok = 1'b0;
        unique case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = is_load;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_misaligned(
        input logic [2:0] f3,
        input logic [1:0] lane
    );
        return ((f3[1:0] == 2'b01) && lane[0]) ||
               ((f3 == F3_W) && (lane != 2'b00));
    endfunction

    function automatic logic [31:0] st_wdata(
        input logic [1:0]  sz,
        input logic [31:0] sd
    );
        logic [31:0] w;
        w = sd;
        unique case (sz)
            2'b00:   w = {4{sd[7:0]}};
            2'b01:   w = {2{sd[15:0]}};
            default: w = sd;
        endcase
        return w;
    endfunction

    // Byte enables cover the lanes touched by the access width.
    function automatic logic [3:0] lane_be(
        input logic [1:0] sz,
        input logic [1:0] lane
    );
        logic [3:0] be;
        be = 4'b1111;
        unique case (sz)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_dmem_if_load_fmt.sv
// Load formatter: picks the byte/half lane out of a memory word and
// sign- or zero-extends it. Ports: i_rdata, i_lane, i_funct3 -> o_data.
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    assign w_half = i_rdata[{i_lane[1], 4'b0000} +: 16];

    always_comb begin
        o_data = i_rdata;
        unique case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_if.sv
// Load/store unit bridging the memory stage to a gnt/rvalid data memory.
// Ports: core side (mem_read/mem_write/funct3/addr/store_data -> read_data,
// stall, misaligned, bus_err) and memory side (dmem_* request/response).
module lsu_dmem_if
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic [31:0]       read_data,
    output logic              stall,
    output logic              misaligned,
    output logic              bus_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata
);

    // Last counter value before the access is declared dead.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e        r_state;
    logic [7:0]        r_cnt;
    logic [31:0]       r_rdata;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic [1:0]        r_lane;
    logic [2:0]        r_f3;
    logic              r_mis;
    logic              r_berr;

    logic              w_access;
    logic              w_legal;
    logic              w_misal;
    logic              w_start;
    logic              w_tmo;
    logic [31:0]       w_load;

    // A load wins when both requests are raised together.
    assign w_access = mem_read | mem_write;
    assign w_legal  = f3_legal(mem_read, funct3);
    assign w_misal  = is_misaligned(funct3, addr[1:0]);
    assign w_start  = w_access & w_legal & ~w_misal;
    assign w_tmo    = (r_cnt >= TMO_LAST);

    lsu_load_fmt u_fmt (
        .i_rdata  (dmem_rdata),
        .i_lane   (r_lane),
        .i_funct3 (r_f3),
        .o_data   (w_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_lane  <= '0;
            r_f3    <= '0;
            r_mis   <= 1'b0;
            r_berr  <= 1'b0;
        end else begin
            r_mis  <= 1'b0;
            r_berr <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        if (!w_legal) begin
                            r_berr <= 1'b1;
                        end else if (w_misal) begin
                            r_mis <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                            r_we    <= ~mem_read;
                            r_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            r_lane  <= addr[1:0];
                            r_f3    <= funct3;
                            r_wdata <= st_wdata(funct3[1:0], store_data);
                            r_be    <= lane_be(funct3[1:0], addr[1:0]);
                            r_cnt   <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt) begin
                        r_req <= 1'b0;
                        if (r_we) begin
                            r_state <= S_DONE;
                            r_cnt   <= '0;
                        end else begin
                            // Counter keeps running: the budget spans REQ+WAIT_R.
                            r_state <= S_WAIT_R;
                            r_cnt   <= r_cnt + 8'd1;
                        end
                    end else if (w_tmo) begin
                        r_req   <= 1'b0;
                        r_berr  <= 1'b1;
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                        if (!r_we) begin
                            r_rdata <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_WAIT_R: begin
                    if (dmem_rvalid) begin
                        r_rdata <= w_load;
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                    end else if (w_tmo) begin
                        r_rdata <= '0;
                        r_berr  <= 1'b1;
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The core is held from the accepting IDLE cycle until DONE.
    assign stall = rst_n &
                   (((r_state == S_IDLE) & w_start) |
                    (r_state == S_REQ) |
                    (r_state == S_WAIT_R));

    assign read_data  = r_rdata;
    assign misaligned = r_mis;
    assign bus_err    = r_berr;
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign dmem_be    = r_be;

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Bench for lsu_dmem_if: directed vector table, randomized transactions
// against a behavioural model, and reset-during-transaction sequences.
module tb_lsu_dmem_if;

    localparam int TMO   = 16;
    localparam int NEVER = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [31:0] read_data;
    logic        stall;
    logic        misaligned;
    logic        bus_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;

    always #5 clk = ~clk;

    lsu_dmem_if #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .addr        (addr),
        .store_data  (store_data),
        .read_data   (read_data),
        .stall       (stall),
        .misaligned  (misaligned),
        .bus_err     (bus_err),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_be     (dmem_be),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    int total = 0;
    int bad   = 0;

    // observations of the last transaction
    bit          o_fin;
    int          o_stall;
    int          o_mis;
    int          o_berr;
    int          o_req;
    bit          o_stable;
    bit          o_post;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic [3:0]  o_be;
    logic        o_we;

    logic [31:0] m_rd;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one instruction; act as memory with gnt after gd extra
    // REQ cycles and rvalid rvd cycles after the gnt cycle+1.
    task automatic run(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rdata, input int gd,
                       input int rvd);
        int  since;
        bit  gdone;
        o_fin = 0; o_stall = 0; o_mis = 0; o_berr = 0; o_req = 0;
        o_stable = 1; o_post = 0;
        since = 0; gdone = 0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3;
        addr = a; store_data = sd;
        for (int k = 0; k < 64 && !o_fin; k++) begin
            if (k > 0) @(negedge clk);
            dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = $urandom;
            if (dmem_req) begin
                o_req++;
                if (o_req == 1) begin
                    o_addr = dmem_addr; o_wdata = dmem_wdata;
                    o_be = dmem_be; o_we = dmem_we;
                end else if (o_addr !== dmem_addr ||
                             o_wdata !== dmem_wdata ||
                             o_be !== dmem_be || o_we !== dmem_we) begin
                    o_stable = 0;
                end
                if (gd != NEVER && o_req == gd + 1) begin
                    dmem_gnt = 1; gdone = 1; since = 0;
                end
            end else if (gdone && rd) begin
                since++;
                if (since == rvd + 1) begin
                    dmem_rvalid = 1; dmem_rdata = rdata;
                end
            end
            #1;
            if (misaligned) o_mis++;
            if (bus_err) o_berr++;
            if (!stall) o_fin = 1;
            else o_stall++;
        end
        @(negedge clk);
        mem_read = 0; mem_write = 0;
        dmem_gnt = 0; dmem_rvalid = 0;
        #1;
        if (misaligned) o_mis++;
        if (bus_err) o_berr++;
        o_post = stall | dmem_req;
    endtask

    task automatic judge(input string t, input bit st, input int es,
                         input bit emis, input bit eberr, input bit ereq,
                         input logic [3:0] ebe, input logic [31:0] ewd,
                         input logic [31:0] erdv, input logic [31:0] a);
        chk({t, " done"}, 32'(o_fin), 32'd1);
        chk({t, " stall_cycles"}, 32'(o_stall), 32'(es));
        chk({t, " misaligned"}, 32'(o_mis), 32'(emis));
        chk({t, " bus_err"}, 32'(o_berr), 32'(eberr));
        chk({t, " req"}, 32'(o_req > 0), 32'(ereq));
        if (ereq && o_req > 0) begin
            chk({t, " addr"}, o_addr, a & 32'hFFFF_FFFC);
            chk({t, " we"}, 32'(o_we), 32'(st));
            chk({t, " stable"}, 32'(o_stable), 32'd1);
            if (st) begin
                chk({t, " be"}, 32'(o_be), 32'(ebe));
                chk({t, " wdata"}, o_wdata, ewd);
            end
        end
        chk({t, " read_data"}, read_data, erdv);
        chk({t, " idle_after"}, 32'(o_post), 32'd0);
    endtask

    // Behavioural reference: arithmetic on the access rules, updates m_rd.
    task automatic model(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rdata, input int gd,
                         input int rvd, output int es, output bit emis,
                         output bit eberr, output bit ereq,
                         output logic [3:0] ebe, output logic [31:0] ewd);
        int          lane, size, need;
        bit          ld, st, legal;
        logic [31:0] b, h;
        ld = rd; st = wr && !rd;
        lane = int'(a % 4);
        size = (int'(f3) % 4 == 0) ? 1 : (int'(f3) % 4 == 1) ? 2 : 4;
        legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                   : (f3 inside {3'd0, 3'd1, 3'd2});
        ebe = (size == 1) ? 4'(1 << lane)
            : (size == 2) ? ((lane >= 2) ? 4'hC : 4'h3) : 4'hF;
        ewd = (size == 1) ? (sd % 256) * 32'h0101_0101
            : (size == 2) ? (sd % 65536) * 32'h0001_0001 : sd;
        es = 0; emis = 0; eberr = 0; ereq = 0;
        if (!ld && !st) return;
        if (!legal) begin
            eberr = 1;
        end else if (lane % size != 0) begin
            emis = 1;
        end else begin
            ereq = 1;
            need = (gd == NEVER) ? 1000 : gd + 1 + (ld ? rvd + 1 : 0);
            if (need > TMO) begin
                eberr = 1;
                es = TMO + 1;
                if (ld) m_rd = 0;
            end else begin
                es = need + 1;
                if (ld) begin
                    b = (rdata >> (8 * lane)) % 256;
                    h = (rdata >> (16 * (lane / 2))) % 65536;
                    case (f3)
                        3'd0: m_rd = (b >= 128) ? b + 32'hFFFF_FF00 : b;
                        3'd4: m_rd = b;
                        3'd1: m_rd = (h >= 32768) ? h + 32'hFFFF_0000 : h;
                        3'd5: m_rd = h;
                        default: m_rd = rdata;
                    endcase
                end
            end
        end
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          gd;
        int          rvd;
        int          stall;
        bit          mis;
        bit          berr;
        bit          req;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rdv;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    initial begin
        int          es;
        bit          emis, eberr, ereq, rd, wr;
        logic [3:0]  ebe;
        logic [31:0] ewd, a, sd, rdata;
        logic [2:0]  f3;
        int          gd, rvd, kind;
        logic [2:0]  lf3 [5];

        lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        tbl[0]  = '{0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 1, 0,
                    3, 0, 0, 1, 4'hF, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1, 0, 3'd0, 32'h203, 32'h0, 32'h80FF7F01, 0, 0,
                    3, 0, 0, 1, 4'h0, 32'h0, 32'hFFFFFF80};
        tbl[2]  = '{1, 0, 3'd4, 32'h203, 32'h0, 32'h80FF7F01, 0, 0,
                    3, 0, 0, 1, 4'h0, 32'h0, 32'h00000080};
        tbl[3]  = '{1, 0, 3'd1, 32'h202, 32'h0, 32'h80FF7F01, 0, 0,
                    3, 0, 0, 1, 4'h0, 32'h0, 32'hFFFF80FF};
        tbl[4]  = '{0, 1, 3'd0, 32'h41, 32'h000000AB, 32'h0, 0, 0,
                    2, 0, 0, 1, 4'b0010, 32'hABABABAB, 32'hFFFF80FF};
        tbl[5]  = '{0, 1, 3'd1, 32'h42, 32'h00001234, 32'h0, 0, 0,
                    2, 0, 0, 1, 4'b1100, 32'h12341234, 32'hFFFF80FF};
        tbl[6]  = '{1, 0, 3'd2, 32'h102, 32'h0, 32'h11111111, 0, 0,
                    0, 1, 0, 0, 4'h0, 32'h0, 32'hFFFF80FF};
        tbl[7]  = '{1, 0, 3'd2, 32'h104, 32'h0, 32'h22222222, NEVER, 0,
                    17, 0, 1, 1, 4'h0, 32'h0, 32'h00000000};
        tbl[8]  = '{1, 0, 3'd5, 32'h206, 32'h0, 32'h80FF7F01, 2, 3,
                    8, 0, 0, 1, 4'h0, 32'h0, 32'h000080FF};
        tbl[9]  = '{1, 0, 3'd3, 32'h0, 32'h0, 32'h33333333, 0, 0,
                    0, 0, 1, 0, 4'h0, 32'h0, 32'h000080FF};
        tbl[10] = '{0, 1, 3'd4, 32'h8, 32'h5A, 32'h0, 0, 0,
                    0, 0, 1, 0, 4'h0, 32'h0, 32'h000080FF};
        tbl[11] = '{1, 1, 3'd2, 32'h10, 32'h77777777, 32'hCAFEF00D, 0, 1,
                    4, 0, 0, 1, 4'h0, 32'h0, 32'hCAFEF00D};
        tbl[12] = '{0, 1, 3'd2, 32'h20, 32'h01020304, 32'h0, 15, 0,
                    17, 0, 0, 1, 4'hF, 32'h01020304, 32'hCAFEF00D};
        tbl[13] = '{1, 0, 3'd1, 32'h201, 32'h0, 32'h44444444, 0, 0,
                    0, 1, 0, 0, 4'h0, 32'h0, 32'hCAFEF00D};
        tbl[14] = '{0, 0, 3'd2, 32'h30, 32'h0, 32'h0, 0, 0,
                    0, 0, 0, 0, 4'h0, 32'h0, 32'hCAFEF00D};
        tbl[15] = '{1, 0, 3'd1, 32'h200, 32'h0, 32'h80FF7F01, 0, 0,
                    3, 0, 0, 1, 4'h0, 32'h0, 32'h00007F01};

        // reset state, with a load pending to show stall is held low
        mem_read = 1; funct3 = 3'd2;
        #12;
        chk("rst read_data", read_data, 32'h0);
        chk("rst dmem_req", 32'(dmem_req), 32'd0);
        chk("rst dmem_we", 32'(dmem_we), 32'd0);
        chk("rst dmem_addr", dmem_addr, 32'h0);
        chk("rst dmem_wdata", dmem_wdata, 32'h0);
        chk("rst dmem_be", 32'(dmem_be), 32'd0);
        chk("rst misaligned", 32'(misaligned), 32'd0);
        chk("rst bus_err", 32'(bus_err), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        @(negedge clk);
        mem_read = 0;
        rst_n = 1;

        for (int i = 0; i < NV; i++) begin
            run(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].sd,
                tbl[i].rdata, tbl[i].gd, tbl[i].rvd);
            judge($sformatf("vec%0d", i), tbl[i].wr && !tbl[i].rd,
                  tbl[i].stall, tbl[i].mis, tbl[i].berr, tbl[i].req,
                  tbl[i].be, tbl[i].wd, tbl[i].rdv, tbl[i].a);
        end

        m_rd = tbl[NV-1].rdv;
        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom % 8);
            rd = (kind < 4) || (kind == 6);
            wr = (kind >= 4) && (kind <= 6);
            f3 = 3'($urandom % 8);
            if ($urandom % 4 != 0)
                f3 = rd ? lf3[$urandom % 5] : 3'($urandom % 3);
            a = $urandom;
            sd = $urandom;
            rdata = $urandom;
            gd = ($urandom % 10 == 0) ? NEVER : int'($urandom % 4);
            rvd = int'($urandom % 4);
            model(rd, wr, f3, a, sd, rdata, gd, rvd,
                  es, emis, eberr, ereq, ebe, ewd);
            run(rd, wr, f3, a, sd, rdata, gd, rvd);
            judge($sformatf("rnd%0d", i), wr && !rd, es, emis, eberr,
                  ereq, ebe, ewd, m_rd, a);
        end

        // known value before the reset sequences
        run(1, 0, 3'd2, 32'h40, 32'h0, 32'h12345678, 0, 0);
        chk("pre_rst read_data", read_data, 32'h12345678);

        // reset while waiting for read data
        @(negedge clk);
        mem_read = 1; funct3 = 3'd2; addr = 32'h30;
        @(negedge clk);
        mem_read = 0;
        #1 chk("rstw req_up", 32'(dmem_req), 32'd1);
        dmem_gnt = 1;
        @(negedge clk);
        dmem_gnt = 0;
        #1 chk("rstw stall_wait", 32'(stall), 32'd1);
        rst_n = 0;
        #1;
        chk("rstw dmem_req", 32'(dmem_req), 32'd0);
        chk("rstw read_data", read_data, 32'h0);
        chk("rstw stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        dmem_rvalid = 1; dmem_rdata = 32'h55;
        @(negedge clk);
        dmem_rvalid = 0;
        #1;
        chk("rstw late_rvalid", read_data, 32'h0);
        chk("rstw stall_after", 32'(stall), 32'd0);

        // reset while the request is on the bus
        @(negedge clk);
        mem_write = 1; funct3 = 3'd2; addr = 32'h48;
        store_data = 32'hA5A5A5A5;
        @(negedge clk);
        mem_write = 0;
        #1 chk("rstq req_up", 32'(dmem_req), 32'd1);
        rst_n = 0;
        #1;
        chk("rstq dmem_req", 32'(dmem_req), 32'd0);
        chk("rstq dmem_be", 32'(dmem_be), 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        #1;
        chk("rstq idle_req", 32'(dmem_req), 32'd0);
        chk("rstq idle_stall", 32'(stall), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
